fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Program-counter and fetch-sequencing stage directly upstream of the control decoder. It drives the instruction ROM address and consumes the decoder's BranchEn, Jump and Ack outputs together with the branch condition. It computes the next PC as sequential, PC-relative branch, or LUT-based jump. It also runs the Start/Done program handshake and counts executed cycles.

Parameters:
PC_W, 10, program counter width; ROM depth is 2^PC_W, and all PC arithmetic wraps modulo 2^PC_W.
OFF_W, 6, width of the signed relative branch offset.
LUT_N, 32, number of jump-target LUT entries; LUT_W = clog2(LUT_N).
CNT_W, 16, cycle counter width.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  program start request; sampled in IDLE and DONE only.
Stall  in  1  holds PC and counter for this cycle while in RUN.
BranchEn  in  1  from decoder: current instruction is a branch.
Jump  in  1  from decoder: 0 = relative branch, 1 = LUT jump.
Ack  in  1  from decoder: current instruction is the halt instruction.
Taken  in  1  branch condition from datapath (1 = take branch).
RelOffset  in  OFF_W  signed two's-complement offset for relative branches.
LutIdx  in  LUT_W  LUT index for jumps.
LutWrEn  in  1  LUT write enable.
LutWrIdx  in  LUT_W  LUT write index.
LutWrData  in  PC_W  LUT write data.
ProgCtr  out  PC_W  current PC; instruction ROM address.
Running  out  1  high in RUN.
Done  out  1  high in DONE.
CycleCount  out  CNT_W  RUN-cycle counter.

Behaviour:
- Reset (asynchronous, Reset=0): ProgCtr=0, state=IDLE, Running=0, Done=0, CycleCount=0, all LUT entries=0. Outputs follow reset immediately, not on the next edge.
- States: IDLE, RUN, DONE. Running and Done are registered state decodes.
  - IDLE: Start=1 -> RUN; ProgCtr=0, CycleCount=0.
  - RUN, Ack=1 and Stall=0 -> DONE; ProgCtr holds (points at the halt instruction); CycleCount increments once for this cycle.
  - DONE: holds PC and counter; Start=1 -> RUN with ProgCtr=0, CycleCount=0.
  - Start in RUN is ignored.
- Next-PC in RUN, evaluated only when Stall=0; priority highest first:
  1. Ack=1: hold.
  2. BranchEn=1, Taken=1, Jump=1: ProgCtr <= LUT[LutIdx].
  3. BranchEn=1, Taken=1, Jump=0: ProgCtr <= ProgCtr + sign_extend(RelOffset), truncated to PC_W.
  4. Otherwise, including BranchEn=1 with Taken=0: ProgCtr <= ProgCtr + 1, truncated.
- Wrap-around: ProgCtr = 2^PC_W-1 with sequential advance gives 0. Relative arithmetic wraps both directions. Offset 0 when taken is a legal self-loop.
- Stall=1 in RUN: ProgCtr, state and CycleCount hold; BranchEn, Jump, Ack and Taken are ignored that cycle.
- CycleCount increments by 1 on every non-stalled RUN cycle and saturates at 2^CNT_W-1; it does not wrap.
- LUT:
  - Writes are accepted in any state and take effect at the edge.
  - A same-cycle write and jump read to the same index: the jump uses the old entry.
  - Out-of-range LUT_N indices are impossible by construction (LUT_N is a power of two).
- Decoder inputs are assumed valid only in RUN and are ignored in IDLE and DONE.
- Single-cycle decision: the PC for the next instruction is visible on ProgCtr one cycle after the decoder inputs are sampled. There are no delay slots.

Test Plan:
- Reset low mid-RUN with ProgCtr=0x05A -> ProgCtr=0, Running=0, Done=0, CycleCount=0 immediately without waiting for an edge. Release, then Start pulse -> Running=1 on the next edge.
- Start, 5 non-branch cycles -> ProgCtr steps 0,1,2,3,4,5; CycleCount=5. PC=0x3FF with sequential advance -> 0x000.
- At PC=0x010, BranchEn=1, Jump=0, Taken=1, RelOffset=6'b111100 (-4) -> PC=0x00C. Same with Taken=0 -> PC=0x011. At PC=0x002, offset -4 -> PC=0x3FE.
- LUT[3]=0x155 written in IDLE. In RUN, BranchEn=1, Jump=1, LutIdx=3, Taken=1 -> PC=0x155. Same cycle also writing LUT[3]=0x0AA -> PC=0x155; a later jump to index 3 -> PC=0x0AA.
- Stall=1 for 3 cycles at PC=0x020 with BranchEn=1, Taken=1 -> PC stays 0x020 and CycleCount is unchanged. Deassert Stall -> branch taken.
- Ack=1 at PC=0x030 after 48 cycles -> Done=1, Running=0, PC holds 0x030, CycleCount=49. Ack together with BranchEn/Taken -> halt wins. Start in DONE -> RUN, PC=0, CycleCount=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter with sequential/relative/LUT-jump next-PC selection,
// Start/Done program handshake and a saturating RUN-cycle counter.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 6,
    parameter int LUT_N = 32,
    parameter int LUT_W = $clog2(LUT_N),
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             Jump,
    input  logic             Ack,
    input  logic             Taken,
    input  logic [OFF_W-1:0] RelOffset,
    input  logic [LUT_W-1:0] LutIdx,
    input  logic             LutWrEn,
    input  logic [LUT_W-1:0] LutWrIdx,
    input  logic [PC_W-1:0]  LutWrData,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] rel_pc;
    logic [PC_W-1:0] next_pc;
    logic [CNT_W-1:0] next_cnt;
    always_comb begin
        rel_pc = ProgCtr + {{(PC_W-OFF_W){RelOffset[OFF_W-1]}}, RelOffset};
        next_pc = Ack ? ProgCtr : (BranchEn && Taken) ? (Jump ? lut[LutIdx] : rel_pc) : ProgCtr + PC_W'(1);
        next_cnt = &CycleCount ? CycleCount : CycleCount + CNT_W'(1);
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            CycleCount <= '0;
            Running    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (Start) begin
                    state      <= RUN;
                    ProgCtr    <= '0;
                    CycleCount <= '0;
                    Running    <= 1'b1;
                    Done       <= 1'b0;
                end
                RUN: if (!Stall) begin
                    ProgCtr    <= next_pc;
                    CycleCount <= next_cnt;
                    if (Ack) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end
    // Write lands at the edge, so a same-cycle jump still reads the old entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else if (LutWrEn) begin
            lut[LutWrIdx] <= LutWrData;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences and a randomized
// run against an arithmetic reference model of the fetch stage.
module tb_fetch_unit;
    logic       Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Stall = 1'b0;
    logic       BranchEn = 1'b0, Jump = 1'b0, Ack = 1'b0, Taken = 1'b0, LutWrEn = 1'b0;
    logic [5:0] RelOffset = '0;
    logic [4:0] LutIdx = '0, LutWrIdx = '0;
    logic [9:0] LutWrData = '0;
    logic [9:0] ProgCtr;
    logic       Running, Done;
    logic [15:0] CycleCount;

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
        .Jump(Jump), .Ack(Ack), .Taken(Taken), .RelOffset(RelOffset), .LutIdx(LutIdx),
        .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx), .LutWrData(LutWrData), .ProgCtr(ProgCtr),
        .Running(Running), .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic [9:0] pc, input logic run,
                             input logic dn, input logic [15:0] cnt);
        check({nm, " pc"}, ProgCtr, pc);
        check({nm, " run"}, Running, run);
        check({nm, " done"}, Done, dn);
        check({nm, " cnt"}, CycleCount, cnt);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ctl = {Start, Stall, BranchEn, Jump, Ack, Taken}; flg = {Running, Done}
    typedef struct {
        logic [5:0] ctl;
        logic [5:0] off;
        logic [4:0] idx;
        logic       we;
        logic [4:0] wi;
        logic [9:0] wd;
        logic [9:0] pc;
        logic [1:0] flg;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic drive(input vec_t v);
        {Start, Stall, BranchEn, Jump, Ack, Taken} = v.ctl;
        RelOffset = v.off;
        LutIdx    = v.idx;
        LutWrEn   = v.we;
        LutWrIdx  = v.wi;
        LutWrData = v.wd;
    endtask

    task automatic idle_inputs();
        {Start, Stall, BranchEn, Jump, Ack, Taken, LutWrEn} = '0;
        RelOffset = '0;
        LutIdx = '0;
        LutWrIdx = '0;
        LutWrData = '0;
    endtask

    int m_st, m_pc, m_cnt;
    int m_lut[32];

    task automatic model_step();
        int off;
        int jt;
        off = (RelOffset >= 6'd32) ? int'(RelOffset) - 64 : int'(RelOffset);
        jt = m_lut[LutIdx];
        if (m_st != 1) begin
            if (Start) begin
                m_st = 1;
                m_pc = 0;
                m_cnt = 0;
            end
        end else if (!Stall) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (Ack) m_st = 2;
            else if (BranchEn && Taken) m_pc = Jump ? jt : (m_pc + off + 1024) % 1024;
            else m_pc = (m_pc + 1) % 1024;
        end
        if (LutWrEn) m_lut[LutWrIdx] = LutWrData;
    endtask

    initial begin
        // Directed table, starting from IDLE after reset
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b1, 5'd3, 10'h155, 10'h000, 2'b00, 16'd0});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b1, 5'd1, 10'h010, 10'h000, 2'b00, 16'd0});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b1, 5'd2, 10'h002, 10'h000, 2'b00, 16'd0});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b1, 5'd5, 10'h3FF, 10'h000, 2'b00, 16'd0});
        tbl.push_back('{6'b000101, 6'h00, 5'd3, 1'b1, 5'd6, 10'h020, 10'h000, 2'b00, 16'd0});
        tbl.push_back('{6'b100000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h000, 2'b10, 16'd0});
        tbl.push_back('{6'b100000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h001, 2'b10, 16'd1});
        tbl.push_back('{6'b001000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h002, 2'b10, 16'd2});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h003, 2'b10, 16'd3});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h004, 2'b10, 16'd4});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h005, 2'b10, 16'd5});
        tbl.push_back('{6'b001101, 6'h00, 5'd5, 1'b0, 5'd0, 10'h000, 10'h3FF, 2'b10, 16'd6});
        tbl.push_back('{6'b000000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h000, 2'b10, 16'd7});
        tbl.push_back('{6'b001101, 6'h00, 5'd1, 1'b0, 5'd0, 10'h000, 10'h010, 2'b10, 16'd8});
        tbl.push_back('{6'b001001, 6'h3C, 5'd0, 1'b0, 5'd0, 10'h000, 10'h00C, 2'b10, 16'd9});
        tbl.push_back('{6'b001101, 6'h00, 5'd1, 1'b0, 5'd0, 10'h000, 10'h010, 2'b10, 16'd10});
        tbl.push_back('{6'b001000, 6'h3C, 5'd0, 1'b0, 5'd0, 10'h000, 10'h011, 2'b10, 16'd11});
        tbl.push_back('{6'b001101, 6'h00, 5'd2, 1'b0, 5'd0, 10'h000, 10'h002, 2'b10, 16'd12});
        tbl.push_back('{6'b001001, 6'h3C, 5'd0, 1'b0, 5'd0, 10'h000, 10'h3FE, 2'b10, 16'd13});
        tbl.push_back('{6'b001101, 6'h00, 5'd3, 1'b1, 5'd3, 10'h0AA, 10'h155, 2'b10, 16'd14});
        tbl.push_back('{6'b001101, 6'h00, 5'd3, 1'b0, 5'd0, 10'h000, 10'h0AA, 2'b10, 16'd15});
        tbl.push_back('{6'b001101, 6'h00, 5'd6, 1'b0, 5'd0, 10'h000, 10'h020, 2'b10, 16'd16});
        tbl.push_back('{6'b011101, 6'h00, 5'd3, 1'b0, 5'd0, 10'h000, 10'h020, 2'b10, 16'd16});
        tbl.push_back('{6'b011011, 6'h05, 5'd3, 1'b0, 5'd0, 10'h000, 10'h020, 2'b10, 16'd16});
        tbl.push_back('{6'b011001, 6'h05, 5'd3, 1'b0, 5'd0, 10'h000, 10'h020, 2'b10, 16'd16});
        tbl.push_back('{6'b001001, 6'h05, 5'd0, 1'b0, 5'd0, 10'h000, 10'h025, 2'b10, 16'd17});
        tbl.push_back('{6'b001011, 6'h05, 5'd0, 1'b0, 5'd0, 10'h000, 10'h025, 2'b01, 16'd18});
        tbl.push_back('{6'b001001, 6'h05, 5'd0, 1'b0, 5'd0, 10'h000, 10'h025, 2'b01, 16'd18});
        tbl.push_back('{6'b100000, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h000, 2'b10, 16'd0});
        tbl.push_back('{6'b001001, 6'h00, 5'd0, 1'b0, 5'd0, 10'h000, 10'h000, 2'b10, 16'd1});

        Reset = 1'b0;
        #2;
        check_all("reset", 10'h000, 1'b0, 1'b0, 16'd0);
        @(negedge Clk) Reset = 1'b1;
        tick();
        check_all("idle", 10'h000, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].flg[1], tbl[i].flg[0], tbl[i].cnt);
        end

        // Asynchronous reset mid-RUN at PC 0x05A
        idle_inputs();
        LutWrEn = 1'b1; LutWrIdx = 5'd8; LutWrData = 10'h05A;
        tick();
        idle_inputs();
        {BranchEn, Jump, Taken} = 3'b111; LutIdx = 5'd8;
        tick();
        check("pre-reset pc", ProgCtr, 10'h05A);
        idle_inputs();
        #2 Reset = 1'b0;
        #1;
        check_all("async reset", 10'h000, 1'b0, 1'b0, 16'd0);
        @(negedge Clk) Reset = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_all("restart", 10'h000, 1'b1, 1'b0, 16'd0);

        // 48 sequential cycles to 0x030, then halt combined with a taken branch
        repeat (48) tick();
        check_all("run48", 10'h030, 1'b1, 1'b0, 16'd48);
        {Ack, BranchEn, Taken} = 3'b111; RelOffset = 6'h10;
        tick();
        idle_inputs();
        check_all("halt", 10'h030, 1'b0, 1'b1, 16'd49);
        tick();
        check_all("done hold", 10'h030, 1'b0, 1'b1, 16'd49);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_all("done restart", 10'h000, 1'b1, 1'b0, 16'd0);

        // Randomized run against the reference model
        @(negedge Clk) Reset = 1'b0;
        @(negedge Clk) Reset = 1'b1;
        m_st = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            Start     = ($urandom_range(0, 99) < 30);
            Stall     = ($urandom_range(0, 99) < 20);
            BranchEn  = ($urandom_range(0, 99) < 40);
            Jump      = $urandom_range(0, 1);
            Ack       = ($urandom_range(0, 99) < 4);
            Taken     = $urandom_range(0, 1);
            RelOffset = 6'($urandom);
            LutIdx    = 5'($urandom);
            LutWrEn   = ($urandom_range(0, 99) < 25);
            LutWrIdx  = 5'($urandom);
            LutWrData = 10'($urandom);
            model_step();
            tick();
            check_all("rand", 10'(m_pc), m_st == 1, m_st == 2, 16'(m_cnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
